lcd_write_sequencer: RTL and testbench
======================================

# lcd_write_sequencer

Byte-level write engine for the HD44780-style character LCD, sitting directly downstream of the LCD clock divider. It turns the divider's slow MSB (~381 Hz, ~2.6 ms period) into single-cycle strobes, runs the power-on initialisation sequence, and then accepts command or data bytes over a valid/ready handshake. Each byte is driven onto the 8-bit LCD bus with a strobe-timed E pulse.

## Interface
- `INIT_WAIT_TICKS`, default 8: strobes to wait after reset before the first init byte, 8 × 2.6 ms ≈ 21 ms (≥ 15 ms power-up).
- `clk`, in, 1: system clock, 50 MHz. The only clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `tick_src`, in, 1: divider MSB. Same clock domain. Used only as an edge source, never as a clock.
- `in_valid`, in, 1: host byte valid.
- `in_ready`, out, 1: block can accept a byte.
- `in_rs`, in, 1: register select; 0 = command, 1 = data.
- `in_data`, in, 8: byte to write.
- `lcd_e`, out, 1: LCD enable.
- `lcd_rs`, out, 1: LCD register select.
- `lcd_rw`, out, 1: LCD read/write; tied 0 (write-only).
- `lcd_db`, out, 8: LCD data bus.
- `init_done`, out, 1: initialisation complete. Sticky until reset.

## Operation
- Strobe generation:
  - `strobe = tick_src & ~tick_prev`, one clk wide.
  - `tick_prev` resets to 1, so a `tick_src` already high at reset release gives no strobe.
- States and transitions:
  - RESET_WAIT: counts `INIT_WAIT_TICKS` strobes, then goes to INIT_LOAD.
  - INIT_LOAD: loads init byte[idx] with rs = 0, then goes to SETUP.
  - IDLE: `in_ready` = 1. On `in_valid & in_ready`, latches `in_rs`/`in_data`, then goes to SETUP.
  - SETUP: `lcd_rs`/`lcd_db` driven, E = 0. On strobe, goes to E_HIGH.
  - E_HIGH: E = 1. On strobe, goes to E_LOW.
  - E_LOW: E = 0, bus held. On strobe:
    - during init: goes to INIT_LOAD (idx+1), or to IDLE with `init_done` = 1 after the last byte;
    - otherwise: goes to IDLE.
- Init byte list, in order: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. `INIT_LEN` = 7, idx is 3 bits.
- The E_LOW hold of one full strobe period (≥ 2.6 ms) covers clear/home execution time (1.52 ms). The block does no busy-flag polling.
- The host byte is captured only at accept. Changes on `in_data` after accept do not reach `lcd_db`.
- `in_valid` while `in_ready` = 0 is ignored. No queuing.
- Bus and E change only on the clk edge after a strobe. RS/DB are stable for the whole SETUP → E_LOW span.

## Timing
- Reset values: `lcd_e` 0, `lcd_rs` 0, `lcd_rw` 0, `lcd_db` 0x00, `in_ready` 0, `init_done` 0, state RESET_WAIT, idx 0, wait counter 0.
- Accept to bus driven: 1 clk.
- Accept to `in_ready` high again: 3 strobes plus 1 clk.
- E high width: exactly one strobe period.
- Init duration: `INIT_WAIT_TICKS` + 21 strobes.
- Reset mid-operation:
  - all outputs return to their reset values on the next clk edge, E included;
  - init restarts from idx 0.
- A strobe in the same cycle as accept is not counted. SETUP waits for the next strobe.

## Configuration
- `LCD_INIT_SEQ_EN` defined:
  - RESET_WAIT and INIT_LOAD are present;
  - the init sequence runs as described above.
- `LCD_INIT_SEQ_EN` undefined:
  - there is no init ROM and no wait counter;
  - after reset the block enters IDLE, with `init_done` and `in_ready` = 1 in the first cycle after `rst` deasserts;
  - the host issues the init commands itself.

## Structure
- `lcd_pkg` holds:
  - state enum `lcd_state_t`;
  - `LCD_INIT_LEN`;
  - init byte constants (`LCD_FUNC_SET` 0x38, `LCD_DISP_ON` 0x0C, `LCD_CLEAR` 0x01, `LCD_ENTRY` 0x06);
  - RS encodings.
- Sub-module `lcd_tick_edge`: rising-edge detector (`tick_src` → `strobe`) with reset-to-1 previous register. It is reusable for later LCD read logic.

## Test plan
- Init sequence:
  - stimulus: `INIT_WAIT_TICKS` = 2, `tick_src` period 8 clk (4 high / 4 low);
  - response: 2 idle strobes, then seven E pulses with `lcd_db` = 38, 38, 38, 38, 0C, 01, 06 and `lcd_rs` = 0;
  - `init_done` and `in_ready` rise 1 clk after strobe 23.
- Data write:
  - stimulus: after init, `in_rs` = 1, `in_data` = 0x41, `in_valid` for 1 clk;
  - response: `lcd_rs` = 1 and `lcd_db` = 0x41 the next clk; E high from strobe 1 to strobe 2; `in_ready` high after strobe 3.
- Busy hold:
  - stimulus: `in_valid` held high, `in_data` changing 0x41 → 0x42 → 0x43 every clk after the first accept;
  - response: only 0x41 is written; `lcd_db` stays stable through E_LOW.
- Reset during E high:
  - stimulus: assert `rst` for 1 clk while `lcd_e` = 1;
  - response: next edge gives `lcd_e` = 0, `lcd_db` = 0x00, `init_done` = 0; a full init then replays.
- Edge suppression:
  - stimulus: `tick_src` held at 1 across reset release;
  - response: no strobe, and the wait counter does not advance until the next 0 → 1 transition.
- Macro off:
  - stimulus: build without `LCD_INIT_SEQ_EN`, release reset;
  - response: `in_ready` = 1 after 1 clk; a 0x01 command produces a single E pulse and no init bytes appear.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD write path.
//   lcd_state_t    : write sequencer FSM states
//   LCD_INIT_LEN   : number of bytes in the power-on init sequence
//   LCD_* bytes    : init command encodings
//   LCD_RS_*       : register-select encodings
//   lcd_init_byte(): init ROM lookup by index
package lcd_pkg;

    typedef enum logic [2:0] {
        StResetWait,
        StInitLoad,
        StIdle,
        StSetup,
        StEHigh,
        StELow
    } lcd_state_t;

    localparam int unsigned LCD_INIT_LEN = 7;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38; // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C; // display on, cursor off
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06; // increment, no shift

    localparam logic LCD_RS_CMD  = 1'b0;
    localparam logic LCD_RS_DATA = 1'b1;

    // Function set is repeated four times; indices past the end also map to it.
    function automatic logic [7:0] lcd_init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd4:    b = LCD_DISP_ON;
            3'd5:    b = LCD_CLEAR;
            3'd6:    b = LCD_ENTRY;
            default: b = LCD_FUNC_SET;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_tick_edge.sv
// Rising-edge detector turning the LCD clock divider MSB into one-clk strobes.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   tick_src : divider MSB, same clock domain (edge source only)
//   strobe   : one clk high per 0->1 transition of tick_src
// The previous-value register resets to 1 so a source already high at reset
// release does not produce a spurious strobe.
module lcd_tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick_src,
    output logic strobe
);

    logic tick_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_prev_q <= 1'b1;
        end else begin
            tick_prev_q <= tick_src;
        end
    end

    assign strobe = tick_src & ~tick_prev_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Byte-level write engine for an HD44780-style character LCD (8-bit bus, write-only).
// Runs the power-on init sequence, then writes host bytes accepted over valid/ready,
// each with a SETUP / E high / E low phase of one divider strobe period apiece.
//   clk, rst            : clock, synchronous active-high reset
//   tick_src            : LCD clock divider MSB (edge source)
//   in_valid/in_ready   : host byte handshake
//   in_rs, in_data      : register select (0 cmd, 1 data) and byte
//   lcd_e/rs/rw/db      : LCD bus, rw tied low
//   init_done           : init complete, sticky until reset
// Build option: define LCD_INIT_SEQ_EN to include the power-on wait and init ROM.
// Without it the block comes up idle one clk after reset and the host sends init.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned INIT_WAIT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_src,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       init_done
);

    logic strobe;

    lcd_tick_edge u_tick_edge (
        .clk      (clk),
        .rst      (rst),
        .tick_src (tick_src),
        .strobe   (strobe)
    );

    lcd_state_t state_q, state_d;
    logic       e_q, e_d;
    logic       rs_q, rs_d;
    logic [7:0] db_q, db_d;
    logic       init_done_q, init_done_d;

`ifdef LCD_INIT_SEQ_EN
    localparam int unsigned WaitW = (INIT_WAIT_TICKS > 1) ? $clog2(INIT_WAIT_TICKS) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(INIT_WAIT_TICKS - 1);
    localparam logic [2:0] InitLast = 3'(LCD_INIT_LEN - 1);
    localparam lcd_state_t ResetState = StResetWait;

    logic [2:0]       idx_q, idx_d;
    logic [WaitW-1:0] wait_q, wait_d;
`else
    localparam lcd_state_t ResetState = StIdle;

    logic unused_wait_ticks;
    assign unused_wait_ticks = ^INIT_WAIT_TICKS;
`endif

    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        db_d        = db_q;
        init_done_d = init_done_q;
`ifdef LCD_INIT_SEQ_EN
        idx_d       = idx_q;
        wait_d      = wait_q;
`else
        // Nothing to initialise: ready from the first cycle out of reset.
        init_done_d = 1'b1;
`endif

        case (state_q)
`ifdef LCD_INIT_SEQ_EN
            StResetWait: begin
                if (strobe) begin
                    if (wait_q == WaitLast) begin
                        state_d = StInitLoad;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
            end
            StInitLoad: begin
                rs_d    = LCD_RS_CMD;
                db_d    = lcd_init_byte(idx_q);
                state_d = StSetup;
            end
`endif
            StIdle: begin
                if (in_valid && in_ready) begin
                    rs_d    = in_rs;
                    db_d    = in_data;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (strobe) state_d = StEHigh;
            end
            StEHigh: begin
                if (strobe) state_d = StELow;
            end
            StELow: begin
                if (strobe) begin
`ifdef LCD_INIT_SEQ_EN
                    if (!init_done_q) begin
                        if (idx_q == InitLast) begin
                            state_d     = StIdle;
                            init_done_d = 1'b1;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = StInitLoad;
                        end
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = ResetState;
        endcase

        // E is registered off the next state so it moves on the same edge as the FSM.
        e_d = (state_d == StEHigh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ResetState;
            e_q         <= 1'b0;
            rs_q        <= LCD_RS_CMD;
            db_q        <= 8'h00;
            init_done_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            idx_q       <= 3'd0;
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            init_done_q <= init_done_d;
`ifdef LCD_INIT_SEQ_EN
            idx_q       <= idx_d;
            wait_q      <= wait_d;
`endif
        end
    end

    // init_done gating keeps ready low during the reset-release cycle.
    assign in_ready  = (state_q == StIdle) && init_done_q;
    assign lcd_e     = e_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_db    = db_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer. Table of host writes plus hand
// sequences for reset during E high and tick edge suppression at reset release.
// Init-sequence checks are compiled in when LCD_INIT_SEQ_EN is defined.
module tb_lcd_write_sequencer;
    import lcd_pkg::*;

    localparam int unsigned WaitTicks = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_src;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;
    logic       init_done;

    int n_tests = 0;
    int n_fail  = 0;

    bit          tick_auto;
    int unsigned ph;
    bit          tb_prev;
    bit          strobe_edge;
    bit          busy_mode;

    always #5 clk = ~clk;

    lcd_write_sequencer #(
        .INIT_WAIT_TICKS (WaitTicks)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_src  (tick_src),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_db    (lcd_db),
        .init_done (init_done)
    );

    typedef struct {
        string      name;
        bit         rs;
        logic [7:0] data;
        bit         busy;
        bit         align;
        bit         exp_rs;
        logic [7:0] exp_db;
    } vec_t;

    vec_t vecs[5];

    // One clk; strobe_edge says whether the edge just taken carried a strobe.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            strobe_edge = 1'b0;
            tb_prev     = 1'b1;
        end else begin
            strobe_edge = tick_src & ~tb_prev;
            tb_prev     = tick_src;
        end
        #1;
        if (tick_auto) begin
            ph       = (ph + 1) % 8;
            tick_src = (ph < 4);
        end
        if (busy_mode) in_data = in_data + 8'd1;
    endtask

    task automatic check_out(input string name, input bit e, input bit rs, input logic [7:0] db,
                             input bit rdy, input bit done);
        n_tests++;
        if (lcd_e !== e || lcd_rs !== rs || lcd_rw !== 1'b0 || lcd_db !== db ||
            in_ready !== rdy || init_done !== done) begin
            n_fail++;
            $display("FAIL %s: got e=%b rs=%b rw=%b db=%h ready=%b done=%b, want e=%b rs=%b rw=0 db=%h ready=%b done=%b",
                     name, lcd_e, lcd_rs, lcd_rw, lcd_db, in_ready, init_done,
                     e, rs, db, rdy, done);
        end
    endtask

    // Step up to and through the next strobe edge; outputs must hold until then.
    task automatic hold_check(input string name, input bit e, input bit rs, input logic [7:0] db,
                              input bit rdy, input bit done);
        bit         bad  = 1'b0;
        bit         seen = 1'b0;
        logic [7:0] bad_db = 8'h00;
        logic       bad_e  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (strobe_edge) begin
                seen = 1'b1;
                break;
            end
            if (!bad && (lcd_e !== e || lcd_rs !== rs || lcd_db !== db || in_ready !== rdy ||
                         init_done !== done)) begin
                bad    = 1'b1;
                bad_db = lcd_db;
                bad_e  = lcd_e;
            end
        end
        n_tests++;
        if (bad || !seen) begin
            n_fail++;
            $display("FAIL %s: hold broken (strobe seen=%b) got e=%b db=%h, want e=%b db=%h",
                     name, seen, bad_e, bad_db, e, db);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) break;
            step();
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: in_ready got %b, want 1 within 50 clk", name, in_ready);
        end
    endtask

`ifdef LCD_INIT_SEQ_EN
    logic [7:0] init_tab [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic init_check(input string tag);
        logic [7:0] prev;
        for (int s = 0; s < int'(WaitTicks); s++) begin
            hold_check({tag, "/wait"}, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        for (int i = 0; i < int'(LCD_INIT_LEN); i++) begin
            prev = (i == 0) ? 8'h00 : init_tab[i-1];
            check_out({tag, "/load"}, 1'b0, 1'b0, prev, 1'b0, 1'b0);
            step();
            check_out({tag, "/setup"}, 1'b0, 1'b0, init_tab[i], 1'b0, 1'b0);
            hold_check({tag, "/setup_hold"}, 1'b0, 1'b0, init_tab[i], 1'b0, 1'b0);
            check_out({tag, "/e_high"}, 1'b1, 1'b0, init_tab[i], 1'b0, 1'b0);
            hold_check({tag, "/e_high_hold"}, 1'b1, 1'b0, init_tab[i], 1'b0, 1'b0);
            check_out({tag, "/e_low"}, 1'b0, 1'b0, init_tab[i], 1'b0, 1'b0);
            hold_check({tag, "/e_low_hold"}, 1'b0, 1'b0, init_tab[i], 1'b0, 1'b0);
        end
        check_out({tag, "/done"}, 1'b0, 1'b0, 8'h06, 1'b1, 1'b1);
    endtask
`endif

    // Release reset and bring the block to idle, checking the path there.
    task automatic bring_up(input string tag);
        rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_check(tag);
`else
        step();
        check_out({tag, "/ready_1clk"}, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`endif
    endtask

    task automatic write_txn(input vec_t v);
        wait_ready({v.name, "/ready"});
        if (v.align) begin
            for (int i = 0; i < 20; i++) begin
                if (tick_src && !tb_prev) break;
                step();
            end
        end
        in_rs     = v.rs;
        in_data   = v.data;
        in_valid  = 1'b1;
        busy_mode = v.busy;
        step();
        if (!v.busy) in_valid = 1'b0;
        check_out({v.name, "/setup"}, 1'b0, v.exp_rs, v.exp_db, 1'b0, 1'b1);
        hold_check({v.name, "/setup_hold"}, 1'b0, v.exp_rs, v.exp_db, 1'b0, 1'b1);
        check_out({v.name, "/e_high"}, 1'b1, v.exp_rs, v.exp_db, 1'b0, 1'b1);
        hold_check({v.name, "/e_high_hold"}, 1'b1, v.exp_rs, v.exp_db, 1'b0, 1'b1);
        check_out({v.name, "/e_low"}, 1'b0, v.exp_rs, v.exp_db, 1'b0, 1'b1);
        in_valid  = 1'b0;
        busy_mode = 1'b0;
        hold_check({v.name, "/e_low_hold"}, 1'b0, v.exp_rs, v.exp_db, 1'b0, 1'b1);
        check_out({v.name, "/idle"}, 1'b0, v.exp_rs, v.exp_db, 1'b1, 1'b1);
    endtask

    initial begin
        vecs[0] = '{"data_41",   LCD_RS_DATA, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[1] = '{"cmd_clear", LCD_RS_CMD,  8'h01, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[2] = '{"busy_hold", LCD_RS_DATA, 8'h41, 1'b1, 1'b0, 1'b1, 8'h41};
        vecs[3] = '{"accept_on_strobe", LCD_RS_CMD, 8'hC0, 1'b0, 1'b1, 1'b0, 8'hC0};
        vecs[4] = '{"data_ff",   LCD_RS_DATA, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rs     = 1'b0;
        in_data   = 8'h00;
        tick_auto = 1'b1;
        ph        = 0;
        tick_src  = 1'b1;
        tb_prev   = 1'b1;
        busy_mode = 1'b0;

        step();
        step();
        check_out("reset_values", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        bring_up("power_on");

`ifndef LCD_INIT_SEQ_EN
        // No init bytes should ever appear on the bus by themselves.
        for (int s = 0; s < 3; s++) begin
            hold_check("no_init_bytes", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
`endif

        foreach (vecs[i]) write_txn(vecs[i]);

        // Reset while E is high.
        wait_ready("rst_mid/ready");
        in_rs    = 1'b1;
        in_data  = 8'h55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        hold_check("rst_mid/setup_hold", 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
        check_out("rst_mid/e_high", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check_out("rst_mid/reset_edge", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        bring_up("rst_mid");

        // tick_src held high across reset release: no strobe until a real 0->1.
        tick_auto = 1'b0;
        tick_src  = 1'b1;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        begin
            bit bad = 1'b0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (lcd_e !== 1'b0 || lcd_db !== 8'h00 || in_ready !== 1'b0 ||
                    init_done !== 1'b0) bad = 1'b1;
            end
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL supp/no_progress: bus or flags moved with tick held high, want quiet");
            end
        end
        tick_src  = 1'b0;
        ph        = 4;
        tick_auto = 1'b1;
        init_check("supp");
`else
        step();
        check_out("supp/ready", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        in_rs    = 1'b0;
        in_data  = 8'h33;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_out("supp/setup", 1'b0, 1'b0, 8'h33, 1'b0, 1'b1);
        begin
            bit bad = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (lcd_e !== 1'b0 || lcd_db !== 8'h33) bad = 1'b1;
            end
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL supp/setup_wait: e went high or bus moved with tick held high");
            end
        end
        tick_src = 1'b0;
        step();
        tick_src = 1'b1;
        step();
        check_out("supp/first_rise", 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        ph        = 0;
        tick_auto = 1'b1;
        hold_check("supp/e_high_hold", 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        check_out("supp/e_low", 1'b0, 1'b0, 8'h33, 1'b0, 1'b1);
        hold_check("supp/e_low_hold", 1'b0, 1'b0, 8'h33, 1'b0, 1'b1);
        check_out("supp/idle", 1'b0, 1'b0, 8'h33, 1'b1, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
